// File: rtl/data_load_seq.sv
// rtl/data_load_seq.sv - frame sequencer for a file-backed stream source
// Turns a word source into SOP/EOP-framed valid/ready traffic, with idle gaps between frames.
module data_load_seq #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cfg_frame_num,
  input  logic [CW-1:0] cfg_frame_len,
  input  logic [CW-1:0] cfg_gap_len,
  input  logic [DW-1:0] src_dout,
  output logic          src_den,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sop,
  output logic          m_eop,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] frame_num_q;
  logic [CW-1:0] frame_len_q;
  logic [CW-1:0] gap_len_q;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] gap_cnt;
  logic [CW-1:0] frame_cnt_q;

  logic hs;
  logic last_word;
  logic last_frame;
  logic last_gap;
  logic cfg_zero;

  assign hs         = m_valid & m_ready;
  assign last_word  = (word_cnt == frame_len_q - CW'(1));
  assign last_frame = ((frame_cnt_q + CW'(1)) == frame_num_q);
  assign last_gap   = (gap_cnt == gap_len_q - CW'(1));
  assign cfg_zero   = (cfg_frame_num == '0) || (cfg_frame_len == '0);

  assign m_data     = src_dout;
  assign frame_cnt  = frame_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = cfg_zero ? DONE : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (hs && last_word) begin
          if (last_frame) begin
            state_nxt = DONE;
          end else if (gap_len_q == '0) begin
            state_nxt = SEND;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_gap) begin
          state_nxt = SEND;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // abort gates the handshake in its own cycle so no word is consumed on it
  always_comb begin
    m_valid = 1'b0;
    src_den = 1'b0;
    m_sop   = 1'b0;
    m_eop   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      SEND: begin
        m_valid = !abort;
        src_den = !abort && m_ready;
        m_sop   = !abort && (word_cnt == '0);
        m_eop   = !abort && last_word;
        busy    = 1'b1;
      end
      GAP: begin
        busy    = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
      end
      default: begin
        busy    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_num_q <= '0;
      frame_len_q <= '0;
      gap_len_q   <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frame_num_q <= cfg_frame_num;
            frame_len_q <= cfg_frame_len;
            gap_len_q   <= cfg_gap_len;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            frame_cnt_q <= '0;
          end
        end
        SEND: begin
          if (hs) begin
            if (last_word) begin
              word_cnt    <= '0;
              gap_cnt     <= '0;
              frame_cnt_q <= frame_cnt_q + CW'(1);
            end else begin
              word_cnt    <= word_cnt + CW'(1);
            end
          end
        end
        GAP: begin
          if (!abort) begin
            gap_cnt <= gap_cnt + CW'(1);
          end
        end
        default: begin
          gap_cnt <= gap_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_load_seq.sv
// tb/tb_data_load_seq.sv - table-driven bench for data_load_seq
// Source model emits 1,2,3,... and advances on src_den.
module tb_data_load_seq;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] cfg_frame_num;
  logic [CW-1:0] cfg_frame_len;
  logic [CW-1:0] cfg_gap_len;
  logic [DW-1:0] src_dout;
  logic          src_den;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sop;
  logic          m_eop;
  logic          busy;
  logic          done;
  logic [CW-1:0] frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  int   src_idx = 0;
  int   den_cnt = 0;
  logic src_clr = 1'b0;

  always #5 clk = ~clk;

  assign src_dout = DW'(src_idx + 1);

  always @(posedge clk) begin
    if (src_clr) begin
      src_idx <= 0;
      den_cnt <= 0;
    end else if (src_den) begin
      src_idx <= src_idx + 1;
      den_cnt <= den_cnt + 1;
    end
  end

  data_load_seq #(.DW(DW), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_frame_num (cfg_frame_num),
    .cfg_frame_len (cfg_frame_len),
    .cfg_gap_len   (cfg_gap_len),
    .src_dout      (src_dout),
    .src_den       (src_den),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_sop         (m_sop),
    .m_eop         (m_eop),
    .busy          (busy),
    .done          (done),
    .frame_cnt     (frame_cnt)
  );

  typedef struct {
    logic        st;
    logic        ab;
    logic        rd;
    logic        vl;
    logic [31:0] dat;
    logic        so;
    logic        eo;
    logic        den;
    logic        bsy;
    logic        dn;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, ab, rd, vl, input logic [31:0] dat,
                              input logic so, eo, den, bsy, dn, input logic [15:0] fc);
    vec_t v;
    v.st = st; v.ab = ab; v.rd = rd; v.vl = vl; v.dat = dat;
    v.so = so; v.eo = eo; v.den = den; v.bsy = bsy; v.dn = dn; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive just after the edge, leave outputs to be sampled at the falling edge
  task automatic step(input logic st, input logic ab, input logic rd);
    @(posedge clk);
    #1;
    start   = st;
    abort   = ab;
    m_ready = rd;
    @(negedge clk);
  endtask

  task automatic set_cfg(input int n, input int l, input int g);
    cfg_frame_num = CW'(n);
    cfg_frame_len = CW'(l);
    cfg_gap_len   = CW'(g);
  endtask

  task automatic clear_src();
    @(posedge clk);
    #1 src_clr = 1'b1;
    @(posedge clk);
    #1 src_clr = 1'b0;
  endtask

  task automatic run_table(input string nm);
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].ab, tbl[i].rd);
      chk($sformatf("%s[%0d].valid", nm, i), {31'd0, m_valid}, {31'd0, tbl[i].vl});
      chk($sformatf("%s[%0d].den", nm, i), {31'd0, src_den}, {31'd0, tbl[i].den});
      chk($sformatf("%s[%0d].busy", nm, i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("%s[%0d].done", nm, i), {31'd0, done}, {31'd0, tbl[i].dn});
      chk($sformatf("%s[%0d].fcnt", nm, i), {16'd0, frame_cnt}, {16'd0, tbl[i].fc});
      if (tbl[i].vl) begin
        chk($sformatf("%s[%0d].data", nm, i), m_data, tbl[i].dat);
        chk($sformatf("%s[%0d].sop", nm, i), {31'd0, m_sop}, {31'd0, tbl[i].so});
        chk($sformatf("%s[%0d].eop", nm, i), {31'd0, m_eop}, {31'd0, tbl[i].eo});
      end
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    set_cfg(0, 0, 0);
    #12;
    chk("reset.valid", {31'd0, m_valid}, 32'd0);
    chk("reset.den", {31'd0, src_den}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.sop_eop", {30'd0, m_sop, m_eop}, 32'd0);
    chk("reset.fcnt", {16'd0, frame_cnt}, 32'd0);
    #10 rst = 1'b1;

    // basic: 2 frames of 4 words, 3 idle cycles between
    clear_src();
    set_cfg(2, 4, 3);
    //            st ab rd vl dat so eo den bsy dn fc
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 2, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 5, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 6, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 7, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 8, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    run_table("basic");
    chk("basic.den_total", den_cnt, 32'd8);

    // backpressure on the second and third cycles of the frame
    clear_src();
    set_cfg(1, 4, 0);
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 2, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    run_table("bp");
    chk("bp.den_total", den_cnt, 32'd4);

    // back-to-back single-word frames
    clear_src();
    set_cfg(3, 1, 0);
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 2, 1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 3, 1, 1, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    run_table("b2b");

    // zero frame count: straight to done, frame_cnt cleared by the start
    clear_src();
    set_cfg(0, 4, 3);
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("zero");
    chk("zero.den_total", den_cnt, 32'd0);

    // abort on word 3 of frame 2, then a fresh run
    clear_src();
    set_cfg(2, 4, 1);
    step(1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    step(0, 0, 1);
    chk("abort.gap_valid", {31'd0, m_valid}, 32'd0);
    step(0, 0, 1);
    chk("abort.f2w1", m_data, 32'd5);
    step(0, 0, 1);
    chk("abort.f2w2", m_data, 32'd6);
    step(0, 1, 1);
    chk("abort.cyc_valid", {31'd0, m_valid}, 32'd0);
    chk("abort.cyc_den", {31'd0, src_den}, 32'd0);
    step(0, 0, 1);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.fcnt", {16'd0, frame_cnt}, 32'd1);
    chk("abort.src_idx", src_idx, 32'd6);
    step(0, 0, 1);
    chk("abort.no_done", {31'd0, done}, 32'd0);
    set_cfg(1, 2, 0);
    step(1, 0, 1);
    step(0, 0, 1);
    chk("rerun.w1", m_data, 32'd7);
    chk("rerun.sop", {31'd0, m_sop}, 32'd1);
    step(0, 0, 1);
    chk("rerun.w2", m_data, 32'd8);
    chk("rerun.eop", {31'd0, m_eop}, 32'd1);
    step(0, 0, 1);
    chk("rerun.done", {31'd0, done}, 32'd1);
    chk("rerun.fcnt", {16'd0, frame_cnt}, 32'd1);

    // asynchronous reset in the middle of a gap
    clear_src();
    set_cfg(2, 2, 5);
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("arst.pre_busy", {31'd0, busy}, 32'd1);
    chk("arst.pre_fcnt", {16'd0, frame_cnt}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.fcnt", {16'd0, frame_cnt}, 32'd0);
    chk("arst.valid_den", {30'd0, m_valid, src_den}, 32'd0);
    chk("arst.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    set_cfg(1, 1, 0);
    step(1, 0, 1);
    chk("arst.idle_busy", {31'd0, busy}, 32'd0);
    step(0, 0, 1);
    chk("arst.w", m_data, 32'd3);
    chk("arst.sop_eop", {30'd0, m_sop, m_eop}, 32'd3);
    step(0, 0, 1);
    chk("arst.done_after", {31'd0, done}, 32'd1);
    chk("arst.fcnt_after", {16'd0, frame_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
